// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // Prefix byte announcing a key release.
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  // Prefix byte for extended keys; carries no key information of its own.
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for both PS/2 pins plus falling-edge detection on
// the synchronized PS/2 clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic data_s_o,
  output logic fall_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;

  // Synchronizer chains; reset to 1 so an idle-high line shows no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign fall_o   = clk_prev_q & ~clk_sync_q[1];
  assign data_s_o = data_sync_q[1];

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: frames bytes off the PS/2 pins, checks parity and
// stop bit, and turns make/break sequences into a held key code plus pulses.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_released,
  output logic       frame_error,
  output logic [1:0] dbg_state_o
);

  logic data_s;
  logic fall;

  ps2_state_t  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [15:0] to_cnt_q, to_cnt_d;

  // Frame-level result, one cycle wide: rx_valid_q qualifies rx_byte_q,
  // rx_err_q reports a rejected or timed-out frame; never both at once.
  logic        rx_valid_q, rx_valid_d;
  logic        rx_err_q, rx_err_d;
  logic [7:0]  rx_byte_q, rx_byte_d;

  logic [7:0]  key_code_q, key_code_d;
  logic        brk_q, brk_d;
  logic        key_valid_q, key_valid_d;
  logic        key_rel_q, key_rel_d;
  logic        ferr_q, ferr_d;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .data_s_o   (data_s),
    .fall_o     (fall)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      to_cnt_q    <= 16'd0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_byte_q   <= 8'h00;
      key_code_q  <= 8'h00;
      brk_q       <= 1'b0;
      key_valid_q <= 1'b0;
      key_rel_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      rx_valid_q  <= rx_valid_d;
      rx_err_q    <= rx_err_d;
      rx_byte_q   <= rx_byte_d;
      key_code_q  <= key_code_d;
      brk_q       <= brk_d;
      key_valid_q <= key_valid_d;
      key_rel_q   <= key_rel_d;
      ferr_q      <= ferr_d;
    end
  end

  // Frame FSM: sample on PS/2 falling edges only, watchdog between edges.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    to_cnt_d   = to_cnt_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    rx_byte_d  = rx_byte_q;

    if (state_q == ST_IDLE) begin
      to_cnt_d = 16'd0;
    end else if (fall) begin
      to_cnt_d = 16'd0;
    end else begin
      to_cnt_d = to_cnt_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        // A high data line on an edge is not a start bit; ignore quietly.
        if (fall && !data_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (data_s && odd_parity_ok(shift_q, par_q)) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shift_q;
          end else begin
            rx_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Stalled keyboard: drop the partial byte and report it.
    if (state_q != ST_IDLE && !fall && to_cnt_q == 16'(TIMEOUT_CYCLES)) begin
      state_d  = ST_IDLE;
      rx_err_d = 1'b1;
      to_cnt_d = 16'd0;
    end
  end

  // Scan-code interpretation: make, break prefix, extended prefix, errors.
  always_comb begin
    key_code_d  = key_code_q;
    brk_d       = brk_q;
    key_valid_d = 1'b0;
    key_rel_d   = 1'b0;
    ferr_d      = 1'b0;

    if (rx_err_q) begin
      ferr_d = 1'b1;
    end else if (rx_valid_q) begin
      if (rx_byte_q == EXT_CODE) begin
        key_code_d = key_code_q;
      end else if (rx_byte_q == BREAK_CODE) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        brk_d     = 1'b0;
        key_rel_d = 1'b1;
        if (rx_byte_q == key_code_q) key_code_d = 8'h00;
      end else begin
        key_code_d  = rx_byte_q;
        key_valid_d = 1'b1;
      end
    end
  end

  assign key_code     = key_code_q;
  assign key_valid    = key_valid_q;
  assign key_released = key_rel_q;
  assign frame_error  = ferr_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver with an expected-event queue.
module tb_ps2_key_receiver;

  localparam int TO   = 200;
  localparam int HALF = 8;
  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_REL   = 2'd2;
  localparam logic [1:0] K_ERR   = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_released;
  logic       frame_error;
  logic [1:0] dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int cycle_cnt   = 0;
  int stop_cycle  = 0;

  // Entry: {check_latency, kind[1:0], key_code[7:0]}
  logic [10:0] exp_q[$];
  logic [7:0]  mdl_code;
  logic        mdl_brk;
  logic [1:0]  mon_kind;
  logic [10:0] mon_e;

  ps2_key_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_released (key_released),
    .frame_error  (frame_error),
    .dbg_state_o  (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: every output pulse pops one expected event.
  always @(negedge clk) begin
    if (!reset && (key_valid || key_released || frame_error)) begin
      chk("exclusive", 32'($onehot({key_valid, key_released, frame_error})), 1);
      mon_kind = key_valid ? K_VALID : (key_released ? K_REL : K_ERR);
      chk("pulse_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("event", {22'd0, mon_kind, key_code}, {22'd0, mon_e[9:0]});
        if (mon_e[10]) chk("latency_le4", 32'((cycle_cnt - stop_cycle) <= 4), 1);
      end
    end
  end

  // Driver: one PS/2 bit, data set while clock high, edge mid-bit.
  task automatic send_bit(input logic b, input bit is_stop);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) stop_cycle = cycle_cnt;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int nbits, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], i == 10);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // Reference model pushes the expected event, then the frame is driven.
  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_par || bad_stop) begin
      exp_q.push_back({1'b1, K_ERR, mdl_code});
    end else if (b == 8'hE0) begin
      mdl_brk = mdl_brk;
    end else if (b == 8'hF0) begin
      mdl_brk = 1'b1;
    end else if (mdl_brk) begin
      mdl_brk = 1'b0;
      if (b == mdl_code) mdl_code = 8'h00;
      exp_q.push_back({1'b1, K_REL, mdl_code});
    end else begin
      mdl_code = b;
      exp_q.push_back({1'b1, K_VALID, b});
    end
    send_frame(b, 11, bad_par, bad_stop);
    drain();
  endtask

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    mdl_code = 8'h00; mdl_brk = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_key_code", key_code, 8'h00);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_released", key_released, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Make code.
    send_byte(8'h1C, 0, 0);
    chk("make_1c", key_code, 8'h1C);
    // Break of the held key clears it; F0 itself is silent.
    send_byte(8'hF0, 0, 0);
    send_byte(8'h1C, 0, 0);
    chk("break_1c", key_code, 8'h00);
    // Parity error keeps the prior key.
    send_byte(8'h24, 0, 0);
    send_byte(8'h32, 1, 0);
    chk("parity_err_keeps", key_code, 8'h24);
    // Break of a different key leaves key_code alone.
    send_byte(8'hF0, 0, 0);
    send_byte(8'h21, 0, 0);
    chk("break_other", key_code, 8'h24);
    // Typematic repeats.
    send_byte(8'h24, 0, 0);
    send_byte(8'h24, 0, 0);
    // Bad stop bit.
    send_byte(8'h15, 0, 1);
    chk("stop_err_keeps", key_code, 8'h24);
    // Lone edge with data high in idle: no start, no error.
    send_bit(1'b1, 0);
    repeat (10) @(negedge clk);
    chk("idle_edge_state", dbg_state, 0);
    // Extended prefix is ignored.
    send_byte(8'hE0, 0, 0);
    send_byte(8'h75, 0, 0);
    chk("ext_75", key_code, 8'h75);

    // Timeout after the 4th data bit.
    exp_q.push_back({1'b0, K_ERR, mdl_code});
    send_frame(8'h43, 5, 0, 0);
    repeat (TO + 5) @(negedge clk);
    drain();
    chk("timeout_state", dbg_state, 0);
    chk("timeout_keeps", key_code, 8'h75);
    send_byte(8'h43, 0, 0);
    chk("after_timeout", key_code, 8'h43);

    // Reset during the parity bit of 8'h2B.
    send_frame(8'h2B, 9, 0, 0);
    @(negedge clk);
    ps2_data = ~^8'h2B;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_key_code", key_code, 8'h00);
    chk("mid_rst_key_valid", key_valid, 0);
    chk("mid_rst_key_released", key_released, 0);
    chk("mid_rst_frame_error", frame_error, 0);
    chk("mid_rst_state", dbg_state, 0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mdl_code = 8'h00; mdl_brk = 1'b0;
    repeat (5) @(negedge clk);
    send_byte(8'h34, 0, 0);
    chk("after_reset_34", key_code, 8'h34);

    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, SHALL set the maximum clk cycles allowed between ps2_clk falling edges inside a frame; legal range 16..65535.
REQ-002 Port clk  input  1  SHALL be the single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port ps2_clk  input  1  SHALL be the raw PS/2 keyboard clock pin, asynchronous to clk.
REQ-005 Port ps2_data  input  1  SHALL be the raw PS/2 keyboard data pin, asynchronous to clk.
REQ-006 Port key_code  output  8  SHALL hold the scan code of the currently pressed key, or 8'h00 when none is pressed; it feeds the seven-segment decoder directly.
REQ-007 Port key_valid  output  1  SHALL pulse for one clk cycle whenever key_code is loaded from a make code.
REQ-008 Port key_released  output  1  SHALL pulse for one clk cycle when a break sequence (F0 xx) completes.
REQ-009 Port frame_error  output  1  SHALL pulse for one clk cycle on a parity error, a bad stop bit or a timeout.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a two-flop synchronizer; a falling edge SHALL be detected when the synchronized ps2_clk is 1 in the previous cycle and 0 in the current cycle.
REQ-011 All sampling of ps2_data SHALL occur only in the cycle in which a falling edge is detected.
REQ-012 The FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-013 In IDLE, a falling edge with ps2_data=0 SHALL enter DATA with the bit count at 0; a falling edge with ps2_data=1 SHALL keep the FSM in IDLE and SHALL NOT flag an error.
REQ-014 DATA SHALL shift in 8 bits LSB-first, one per falling edge, and SHALL enter PARITY after the 8th bit.
REQ-015 PARITY SHALL sample one bit and enter STOP; the frame's parity check SHALL pass when the 8 data bits plus the parity bit contain an odd number of ones.
REQ-016 STOP SHALL sample one bit and return to IDLE; the frame SHALL be accepted only if the stop bit is 1 and the parity check passed; otherwise frame_error SHALL pulse and the byte SHALL be discarded.
REQ-017 An accepted byte SHALL be processed in the clk cycle after the stop-bit edge is detected; the worst-case latency from the pin edge to the outputs SHALL be 4 clk cycles.
REQ-018 Accepted byte 8'hE0 SHALL be ignored, with no output change and no pulse.
REQ-019 Accepted byte 8'hF0 SHALL set break_pending and SHALL NOT produce a pulse.
REQ-020 An accepted byte arriving with break_pending=1 SHALL clear break_pending and pulse key_released.
REQ-021 In that case, key_code SHALL become 8'h00 if the byte equals the current key_code, and SHALL be left unchanged otherwise.
REQ-022 Any other accepted byte with break_pending=0 SHALL load key_code and pulse key_valid, including typematic repeats of the same code.
REQ-023 In any state other than IDLE, a timeout counter SHALL reset on each falling edge.
REQ-024 If that counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE, pulse frame_error and discard the partial byte.
REQ-025 A frame error or timeout SHALL leave key_code and break_pending unchanged.
REQ-026 At most one of key_valid, key_released and frame_error SHALL be high in any cycle.

Reset
REQ-027 While reset is asserted, the FSM SHALL be in IDLE, key_code SHALL be 8'h00, key_valid, key_released and frame_error SHALL be 0, break_pending SHALL be 0, and the shift register and counters SHALL be 0.
REQ-028 The synchronizer flops SHALL reset to 1, so that the line idles high and no spurious edge is seen.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; the first frame after deassertion SHALL be received correctly.

Structure
REQ-030 Package ps2_pkg SHALL hold the FSM state type and the constants BREAK_CODE=8'hF0 and EXT_CODE=8'hE0.
REQ-031 The synchronizer and falling-edge detector SHALL be a sub-module named ps2_sync_edge, instantiated once per design (it synchronizes both lines).

Verification
REQ-032 Scenario: send make 8'h1C with correct odd parity -> key_code=8'h1C and one key_valid pulse within 4 clk of the stop edge.
REQ-033 Scenario: send 8'h1C, then F0, then 1C -> key_valid once, then key_released once, key_code=8'h00, and no pulse on F0.
REQ-034 Scenario: send 8'h32 with the parity bit inverted -> frame_error pulses once and key_code keeps its prior value.
REQ-035 Scenario: send 8'h24, then F0, then 8'h21 -> key_released pulses and key_code stays 8'h24.
REQ-036 Scenario: stop ps2_clk after the 4th data bit for TIMEOUT_CYCLES+5 cycles, then send 8'h43 -> one frame_error pulse, then key_code=8'h43.
REQ-037 Scenario: assert reset during the parity bit of 8'h2B, then send 8'h34 -> all outputs are 0 during reset, and afterwards key_code=8'h34 with one key_valid pulse.
